// File: rtl/simon_data_out.sv
// SIMON output packetiser: turns a finished block into a count/info-tagged packet.
// Optional one-entry result buffer under SIMON_OUT_BUF_EN.
module simon_data_out #(
   parameter int         N    = 32,
   parameter logic [3:0] MODE = 4'h0
) (
   input  logic                   clk,
   input  logic                   R,
   input  logic                   newRESULT,
   input  logic [2*N-1:0]         resDATA,
   input  logic [7:0]             resINFO,
   output logic                   loadRESULT,
   output logic [(N/2+2)*8-1:0]   out,
   output logic                   out_newPKT,
   input  logic                   out_loadPKT,
   output logic                   out_donePKT,
   output logic [7:0]             countOUT
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      SEND    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t         state;
   state_t         state_n;
   logic           take_new;
   logic           take_buf;
   logic           buf_load;
   logic           buf_full;
   logic [7:0]     count;
   logic [2*N-1:0] cap_data;
   logic [7:0]     cap_info;
   logic [7:0]     info_byte;

   assign info_byte = {cap_info[7:6], 1'b0, 1'b1, MODE};

`ifdef SIMON_OUT_BUF_EN
   logic [2*N-1:0] buf_data;
   logic [7:0]     buf_info;
   logic           buf_full_q;

   assign buf_full = buf_full_q;
`else
   assign buf_full = 1'b0;
`endif

   assign out_donePKT = !R && (state == IDLE) && !newRESULT && !buf_full;

   always_comb begin
      state_n  = state;
      take_new = 1'b0;
      take_buf = 1'b0;
      buf_load = 1'b0;
      unique case (state)
         IDLE: begin
            if (newRESULT) begin
               state_n  = CAPTURE;
               take_new = 1'b1;
            end
         end
         CAPTURE: state_n = SEND;
         SEND: begin
            if (out_loadPKT)
               state_n = RELEASE;
         end
         RELEASE: begin
            if (!out_loadPKT) begin
               state_n = IDLE;
               // a buffered block skips IDLE so packet order stays sequential
               if (buf_full) begin
                  state_n  = CAPTURE;
                  take_buf = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
`ifdef SIMON_OUT_BUF_EN
      if ((state == SEND || state == RELEASE) && newRESULT && !buf_full)
         buf_load = 1'b1;
`endif
   end

   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         state      <= IDLE;
         loadRESULT <= 1'b0;
         out        <= '0;
         out_newPKT <= 1'b0;
         countOUT   <= 8'h00;
         count      <= 8'h00;
         cap_data   <= '0;
         cap_info   <= 8'h00;
      end else begin
         state      <= state_n;
         loadRESULT <= take_new | buf_load;
         if (take_new) begin
            cap_data <= resDATA;
            cap_info <= resINFO;
         end
`ifdef SIMON_OUT_BUF_EN
         if (take_buf) begin
            cap_data <= buf_data;
            cap_info <= buf_info;
         end
`endif
         if (state == CAPTURE) begin
            out        <= {info_byte, count, {(2*N){1'b0}}, cap_data};
            out_newPKT <= 1'b1;
            countOUT   <= count;
            count      <= count + 8'd1;
         end
         if (state == SEND && out_loadPKT)
            out_newPKT <= 1'b0;
      end
   end

`ifdef SIMON_OUT_BUF_EN
   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         buf_data   <= '0;
         buf_info   <= 8'h00;
         buf_full_q <= 1'b0;
      end else begin
         if (buf_load) begin
            buf_data   <= resDATA;
            buf_info   <= resINFO;
            buf_full_q <= 1'b1;
         end else if (take_buf) begin
            buf_full_q <= 1'b0;
         end
      end
   end
`endif

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!R && state == CAPTURE && cap_info[4])
         $display("OUTPUT ERROR - INFO FLAG");
   end
`endif

endmodule

// File: doc/simon_data_out.md
Name: simon_data_out

Overview:
- Output packetiser for the SIMON core. It is the transmit-side counterpart of the input packet receiver.
- Takes a finished ciphertext/plaintext block (2 x N-bit words) from the core together with the info byte of the packet that produced it.
- Builds an (N/2+2)-byte output packet: data bytes, count byte, info byte.
- Presents the packet to the host interface with a level/acknowledge handshake.

Parameters:
- N, 32, word size in bits (multiple of 8; data region = 4 words = N/2 bytes).
- MODE, 4'h0, 4-bit mode code written into info[3:0] of every output packet.

Ports:
- clk  in  1  system clock.
- R  in  1  asynchronous active-high reset.
- newRESULT  in  1  level; core holds a finished block on resDATA/resINFO.
- resDATA  in  2xN  result words; [0] is the first word.
- resINFO  in  8  info byte of the originating input packet.
- loadRESULT  out  1  one-cycle pulse; block has captured resDATA/resINFO. Core drops newRESULT on the next cycle.
- out  out  (N/2+2)x8  packet bus, byte-indexed as on the input side.
- out_newPKT  out  1  level; packet on out is valid.
- out_loadPKT  in  1  host has read out (level; host holds it until out_newPKT falls).
- out_donePKT  out  1  high when idle with nothing buffered.
- countOUT  out  8  count byte of the most recently sent packet.

Behaviour:
- Reset (R=1, async): all outputs, state, count register and capture registers go to 0; state=IDLE. out_donePKT reads 1 once R is released. Reset mid-handshake drops the packet; the next packet uses count 0.
- Packet layout:
  - data[0] = bytes N/8-1..0 = word0; data[1] = bytes N/4-1..N/8 = word1; data[2], data[3] = 0.
  - byte N/2 = count.
  - byte N/2+1 = info = {resINFO[7:6], 1'b0, 1'b1, MODE}. Bit4 = output-packet flag, always 1. Bit5 (key flag) is always 0.
- FSM states IDLE, CAPTURE, SEND, RELEASE:
  - IDLE: if newRESULT -> CAPTURE. Latch resDATA/resINFO and assert loadRESULT for exactly this transition cycle.
  - CAPTURE: drive out from the latched data and the current count register; out_newPKT<=1; countOUT<=count; count<=count+1 (mod 256, 0xFF wraps to 0x00) -> SEND.
  - SEND: hold out stable. When out_loadPKT=1: out_newPKT<=0 -> RELEASE.
  - RELEASE: wait for out_loadPKT=0 -> IDLE. A new result cannot start until the host releases its acknowledge.
- Latency: newRESULT high in IDLE -> loadRESULT on the next edge -> out_newPKT on the edge after that (2 cycles).
- out holds its last value after out_newPKT falls. It is only rewritten in CAPTURE.
- out_donePKT = (state==IDLE) && !newRESULT && buffer empty.
- If resINFO[4]=1 (the core passed an output-flagged info byte), the packet is still sent and $display("OUTPUT ERROR - INFO FLAG") is issued.
- If out_loadPKT is already high on entry to SEND, the transition happens that cycle; out_newPKT is high for exactly 1 cycle.

Optional Feature:
- SIMON_OUT_BUF_EN defined:
  - Adds a one-entry result buffer.
  - In SEND/RELEASE, if newRESULT=1 and the buffer is empty, capture into the buffer and pulse loadRESULT.
  - On RELEASE->IDLE with the buffer full, go straight to CAPTURE using buffer contents (no loadRESULT pulse); the buffer then empties.
  - Packet order and counts stay strictly sequential.
- Undefined: no buffer. loadRESULT only pulses from IDLE, and the core stalls while a packet is in flight.

Test Plan:
- Reset release, idle -> out_newPKT=0, loadRESULT=0, out_donePKT=1, out=0, countOUT=0.
- newRESULT with resDATA={32'h6565_6877,32'hc69b_e9bb}, resINFO=8'h80 (N=32), host acks 3 cycles after out_newPKT -> loadRESULT 1 cycle; then out_newPKT=1 with:
  - word0 bytes = c69be9bb, word1 bytes = 65656877, data[2..3]=0;
  - count byte 00, info byte 8'h90.
- Hold out_loadPKT high 5 cycles, then issue a second result -> no second loadRESULT until out_loadPKT=0; second packet count byte 01.
- Send 257 packets back to back -> count bytes 00..FF then 00; countOUT matches each.
- Assert R while in SEND -> out_newPKT=0 asynchronously; the next packet carries count 00.
- With SIMON_OUT_BUF_EN, a second result arrives during SEND -> loadRESULT pulses immediately; the second packet appears 1 cycle after RELEASE exits, with count 01. Without the macro, loadRESULT is delayed until IDLE.
